// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state
// encodings, ALU/PC-select codes and small opcode classification helpers.
package ctrl_pkg;

  localparam int OP_W = 6;
  typedef logic [OP_W-1:0] op_t;

  // Instruction opcodes (IR[31:26]).
  localparam op_t OP_ADD  = 6'b000000;
  localparam op_t OP_SUB  = 6'b000001;
  localparam op_t OP_ADDI = 6'b000010;
  localparam op_t OP_OR   = 6'b010000;
  localparam op_t OP_AND  = 6'b010001;
  localparam op_t OP_ORI  = 6'b010010;
  localparam op_t OP_SLT  = 6'b100110;
  localparam op_t OP_SW   = 6'b110000;
  localparam op_t OP_LW   = 6'b110001;
  localparam op_t OP_BEQ  = 6'b110100;
  localparam op_t OP_BNE  = 6'b110101;
  localparam op_t OP_J    = 6'b111000;
  localparam op_t OP_HALT = 6'b111111;

  // Controller states; sHALT reuses S_ID and is told apart by the halted flag.
  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Next-PC select codes.
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // Register-register ALU ops (destination is rd).
  function automatic logic is_rtype(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT: is_rtype = 1'b1;
      default:                               is_rtype = 1'b0;
    endcase
  endfunction

  // Any op that takes the EXE_AL / WB_AL path.
  function automatic logic is_alu(input op_t op);
    case (op)
      OP_ADDI, OP_ORI: is_alu = 1'b1;
      default:         is_alu = is_rtype(op);
    endcase
  endfunction

  // Loads and stores.
  function automatic logic is_mem(input op_t op);
    case (op)
      OP_SW, OP_LW: is_mem = 1'b1;
      default:      is_mem = 1'b0;
    endcase
  endfunction

  // Conditional branches.
  function automatic logic is_branch(input op_t op);
    case (op)
      OP_BEQ, OP_BNE: is_branch = 1'b1;
      default:        is_branch = 1'b0;
    endcase
  endfunction

  // Everything the controller knows how to sequence.
  function automatic logic is_legal(input op_t op);
    case (op)
      OP_J, OP_HALT: is_legal = 1'b1;
      default:       is_legal = is_alu(op) | is_mem(op) | is_branch(op);
    endcase
  endfunction

  // Immediate-operand instructions feed the extender into ALU input B.
  function automatic logic uses_imm(input op_t op);
    case (op)
      OP_ADDI, OP_ORI, OP_SW, OP_LW: uses_imm = 1'b1;
      default:                       uses_imm = 1'b0;
    endcase
  endfunction

  // ALU function for each opcode; address arithmetic uses add, compares use sub.
  function automatic logic [2:0] alu_op_of(input op_t op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: alu_op_of = ALU_SUB;
      OP_OR, OP_ORI:          alu_op_of = ALU_OR;
      OP_AND:                 alu_op_of = ALU_AND;
      OP_SLT:                 alu_op_of = ALU_SLT;
      default:                alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
);
  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            PCWre;
  logic [1:0]      PCSrc;
  logic            IRWre;
  logic            RegWre;
  logic            RegDst;
  logic            ALUSrcB;
  logic [2:0]      ALUOp;
  logic            ExtSel;
  logic            mRD;
  logic            mWR;
  logic            DBDataSrc;
  logic [2:0]      state;
  logic            halted;
  logic            illegal;
  logic [CNTW-1:0] retired;

  modport master (
    input  opcode, zero,
    output PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp, ExtSel,
           mRD, mWR, DBDataSrc, state, halted, illegal, retired
  );

  modport slave (
    output opcode, zero,
    input  PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp, ExtSel,
           mRD, mWR, DBDataSrc, state, halted, illegal, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// Moore-style control decode: maps (state, halted, opcode, zero) onto the
// datapath control lines. Purely combinational; state lives in the top.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       halted,
  input  op_t        opcode,
  input  logic       zero,
  output logic       IRWre,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       RegWre,
  output logic       RegDst,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc
);

  logic taken_s;

  // Branch decision: beq taken on zero, bne taken on not-zero.
  always_comb begin
    taken_s = 1'b0;
    if (opcode == OP_BEQ) begin
      taken_s = zero;
    end else if (opcode == OP_BNE) begin
      taken_s = ~zero;
    end else begin
      taken_s = 1'b0;
    end
  end

  // Control line decode; everything idles at 0 in sIF (except IRWre) and in sHALT.
  always_comb begin
    IRWre     = 1'b0;
    PCWre     = 1'b0;
    PCSrc     = PCSRC_SEQ;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    if (halted) begin
      PCWre = 1'b0;
    end else begin
      case (state)
        S_IF: begin
          IRWre = 1'b1;
        end
        S_ID: begin
          // j and undefined opcodes retire straight out of decode.
          if (opcode == OP_J) begin
            PCWre = 1'b1;
            PCSrc = PCSRC_JMP;
          end else if (!is_legal(opcode)) begin
            PCWre = 1'b1;
          end else begin
            PCWre = 1'b0;
          end
        end
        S_EXE_AL, S_EXE_LS: begin
          PCWre = 1'b0;
        end
        S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        S_MEM: begin
          if (opcode == OP_LW) begin
            mRD = 1'b1;
          end else if (opcode == OP_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end else begin
            mRD = 1'b0;
          end
        end
        S_WB_LD: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          DBDataSrc = 1'b1;
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = taken_s ? PCSRC_BR : PCSRC_SEQ;
        end
        default: begin
          PCWre = 1'b0;
        end
      endcase
      // Operand/ALU selects follow the opcode once it has been latched in IR.
      if (state != S_IF) begin
        ALUOp   = alu_op_of(opcode);
        ALUSrcB = uses_imm(opcode);
        ExtSel  = (opcode != OP_ORI);
        RegDst  = is_rtype(opcode);
      end else begin
        ALUOp = ALU_ADD;
      end
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multicycle CPU controller: sequences IF/ID/EXE/MEM/WB, tracks halt and
// illegal-opcode status and counts retired instructions.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic                CLK,
  input  logic                Reset,
  multi_cycle_ctrl_if.master  bus
);

  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_e          state_r;
  logic            halted_r;
  logic            illegal_r;
  logic [CNTW-1:0] retired_r;

  logic [OPW-1:0]  opcode_s;
  logic            IRWre_s;
  logic            PCWre_s;
  logic [1:0]      PCSrc_s;
  logic            RegWre_s;
  logic            RegDst_s;
  logic            ALUSrcB_s;
  logic [2:0]      ALUOp_s;
  logic            ExtSel_s;
  logic            mRD_s;
  logic            mWR_s;
  logic            DBDataSrc_s;

  assign opcode_s = bus.opcode;

  ctrl_decode u_decode (
    .state     (state_r),
    .halted    (halted_r),
    .opcode    (opcode_s),
    .zero      (bus.zero),
    .IRWre     (IRWre_s),
    .PCWre     (PCWre_s),
    .PCSrc     (PCSrc_s),
    .RegWre    (RegWre_s),
    .RegDst    (RegDst_s),
    .ALUSrcB   (ALUSrcB_s),
    .ALUOp     (ALUOp_s),
    .ExtSel    (ExtSel_s),
    .mRD       (mRD_s),
    .mWR       (mWR_s),
    .DBDataSrc (DBDataSrc_s)
  );

  // Sequencer: state, halt/illegal flags and the retired-instruction counter.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r   <= S_IF;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      retired_r <= CNT_ZERO;
    end else begin
      // Every instruction raises PCWre exactly once, in its final cycle.
      if (PCWre_s) begin
        retired_r <= retired_r + CNT_ONE;
      end
      if (halted_r) begin
        state_r <= S_ID;
      end else begin
        case (state_r)
          S_IF: begin
            state_r <= S_ID;
          end
          S_ID: begin
            if (is_alu(opcode_s)) begin
              state_r <= S_EXE_AL;
            end else if (is_mem(opcode_s)) begin
              state_r <= S_EXE_LS;
            end else if (is_branch(opcode_s)) begin
              state_r <= S_EXE_BR;
            end else if (opcode_s == OP_HALT) begin
              state_r  <= S_ID;
              halted_r <= 1'b1;
            end else begin
              // j and undefined opcodes complete here.
              state_r <= S_IF;
              if (!is_legal(opcode_s)) begin
                illegal_r <= 1'b1;
              end
            end
          end
          S_EXE_AL: state_r <= S_WB_AL;
          S_WB_AL:  state_r <= S_IF;
          S_EXE_LS: state_r <= S_MEM;
          S_MEM:    state_r <= (opcode_s == OP_LW) ? S_WB_LD : S_IF;
          S_WB_LD:  state_r <= S_IF;
          S_EXE_BR: state_r <= S_IF;
          default:  state_r <= S_IF;
        endcase
      end
    end
  end

  assign bus.IRWre     = IRWre_s;
  assign bus.PCWre     = PCWre_s;
  assign bus.PCSrc     = PCSrc_s;
  assign bus.RegWre    = RegWre_s;
  assign bus.RegDst    = RegDst_s;
  assign bus.ALUSrcB   = ALUSrcB_s;
  assign bus.ALUOp     = ALUOp_s;
  assign bus.ExtSel    = ExtSel_s;
  assign bus.mRD       = mRD_s;
  assign bus.mWR       = mWR_s;
  assign bus.DBDataSrc = DBDataSrc_s;
  assign bus.state     = state_r;
  assign bus.halted    = halted_r;
  assign bus.illegal   = illegal_r;
  assign bus.retired   = retired_r;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed and random instruction streams checked
// against an instruction-level model (cycle-count table, retire count,
// sticky illegal flag).
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int C_ALU = 0, C_SW = 1, C_LW = 2, C_BR = 3, C_J = 4, C_ILL = 5, C_HALT = 6;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] m_ret = 32'd0;
  logic        m_ill = 1'b0;
  logic [5:0]  legal_ops [12] = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                                  OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J};

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT: return C_ALU;
      OP_SW:          return C_SW;
      OP_LW:          return C_LW;
      OP_BEQ, OP_BNE: return C_BR;
      OP_J:           return C_J;
      OP_HALT:        return C_HALT;
      default:        return C_ILL;
    endcase
  endfunction

  // Instruction length in cycles.
  function automatic int ncyc(input int c);
    case (c)
      C_ALU, C_SW: return 4;
      C_LW:        return 5;
      C_BR:        return 3;
      default:     return 2;
    endcase
  endfunction

  // Expected state code in cycle k (1-based) of an instruction of class c.
  function automatic logic [2:0] exp_state(input int c, input int k);
    if (k == 1) return 3'd0;
    if (k == 2) return 3'd1;
    case (c)
      C_ALU:      return (k == 3) ? 3'd6 : 3'd7;
      C_SW, C_LW: return (k == 3) ? 3'd2 : ((k == 4) ? 3'd3 : 3'd4);
      C_BR:       return 3'd5;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_aluop(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return 3'b001;
      OP_OR, OP_ORI:          return 3'b010;
      OP_AND:                 return 3'b011;
      OP_SLT:                 return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  // Run one complete instruction starting just after a negedge in sIF.
  task automatic run_instr(input logic [5:0] op, input logic zsel);
    int c, n;
    logic [1:0] psrc;
    logic wr_reg, imm, rtype;
    string t;
    c = cls_of(op);
    n = ncyc(c);
    psrc = 2'b00;
    if (c == C_J) psrc = 2'b10;
    else if (c == C_BR && ((op == OP_BEQ && zsel) || (op == OP_BNE && !zsel))) psrc = 2'b01;
    wr_reg = (c == C_ALU || c == C_LW);
    imm    = (op == OP_ADDI || op == OP_ORI || op == OP_SW || op == OP_LW);
    rtype  = (op == OP_ADD || op == OP_SUB || op == OP_OR || op == OP_AND || op == OP_SLT);
    bus.opcode = op;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge CLK);
        @(negedge CLK);
      end
      bus.zero = (c == C_BR && k == 3) ? zsel : 1'($urandom_range(0, 1));
      #1;
      t = $sformatf("op=%b k=%0d", op, k);
      if (k == 1) begin
        chk({t, " retired"}, bus.retired, m_ret);
        chk({t, " illegal"}, 32'(bus.illegal), 32'(m_ill));
        chk({t, " halted"},  32'(bus.halted), 32'd0);
        chk({t, " ALUOp_if"}, 32'(bus.ALUOp), 32'd0);
        chk({t, " ExtSel_if"}, 32'(bus.ExtSel), 32'd0);
        chk({t, " ALUSrcB_if"}, 32'(bus.ALUSrcB), 32'd0);
        chk({t, " RegDst_if"}, 32'(bus.RegDst), 32'd0);
      end
      chk({t, " state"},     32'(bus.state),     32'(exp_state(c, k)));
      chk({t, " PCWre"},     32'(bus.PCWre),     32'(k == n));
      chk({t, " PCSrc"},     32'(bus.PCSrc),     (k == n) ? 32'(psrc) : 32'd0);
      chk({t, " IRWre"},     32'(bus.IRWre),     32'(k == 1));
      chk({t, " RegWre"},    32'(bus.RegWre),    32'(wr_reg && k == n));
      chk({t, " mRD"},       32'(bus.mRD),       32'(c == C_LW && k == 4));
      chk({t, " mWR"},       32'(bus.mWR),       32'(c == C_SW && k == 4));
      chk({t, " DBDataSrc"}, 32'(bus.DBDataSrc), 32'(c == C_LW && k == 5));
      if (k == 3) begin
        chk({t, " ALUOp"},   32'(bus.ALUOp),   32'(exp_aluop(op)));
        chk({t, " ALUSrcB"}, 32'(bus.ALUSrcB), 32'(imm));
        chk({t, " ExtSel"},  32'(bus.ExtSel),  32'(op != OP_ORI));
        chk({t, " RegDst"},  32'(bus.RegDst),  32'(rtype));
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    m_ret = m_ret + 32'd1;
    if (c == C_ILL) m_ill = 1'b1;
  endtask

  // halt: fetch + decode, then parked for 20 cycles regardless of inputs.
  task automatic run_halt();
    bus.opcode = OP_HALT;
    bus.zero = 1'b0;
    #1;
    chk("halt k=1 state", 32'(bus.state), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("halt k=2 state",  32'(bus.state),  32'd1);
    chk("halt k=2 halted", 32'(bus.halted), 32'd0);
    chk("halt k=2 PCWre",  32'(bus.PCWre),  32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      bus.opcode = 6'($urandom_range(0, 63));
      bus.zero   = 1'($urandom_range(0, 1));
      #1;
      chk("halt state",   32'(bus.state),  32'd1);
      chk("halt halted",  32'(bus.halted), 32'd1);
      chk("halt PCWre",   32'(bus.PCWre),  32'd0);
      chk("halt IRWre",   32'(bus.IRWre),  32'd0);
      chk("halt RegWre",  32'(bus.RegWre), 32'd0);
      chk("halt mWR",     32'(bus.mWR),    32'd0);
      chk("halt retired", bus.retired,     m_ret);
    end
  endtask

  // Assert reset away from the clock edge, hold one cycle, release.
  task automatic do_reset();
    Reset = 1'b0;
    #1;
    chk("rst state",   32'(bus.state),   32'd0);
    chk("rst IRWre",   32'(bus.IRWre),   32'd1);
    chk("rst PCWre",   32'(bus.PCWre),   32'd0);
    chk("rst RegWre",  32'(bus.RegWre),  32'd0);
    chk("rst mRD",     32'(bus.mRD),     32'd0);
    chk("rst mWR",     32'(bus.mWR),     32'd0);
    chk("rst halted",  32'(bus.halted),  32'd0);
    chk("rst illegal", 32'(bus.illegal), 32'd0);
    chk("rst retired", bus.retired,      32'd0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst hold state",  32'(bus.state),  32'd0);
    chk("rst hold RegWre", 32'(bus.RegWre), 32'd0);
    m_ret = 32'd0;
    m_ill = 1'b0;
    Reset = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    bus.opcode = OP_ADD;
    bus.zero   = 1'b0;
    @(negedge CLK);
    do_reset();

    // Directed: ALU/memory stream, branches, jump, undefined opcode.
    run_instr(OP_ADD, 1'b0);
    run_instr(OP_ADDI, 1'b0);
    run_instr(OP_LW, 1'b0);
    run_instr(OP_SW, 1'b0);
    #1;
    chk("retired after 17 cycles", bus.retired, 32'd4);
    run_instr(OP_BEQ, 1'b1);
    run_instr(OP_BEQ, 1'b0);
    run_instr(OP_BNE, 1'b0);
    run_instr(OP_BNE, 1'b1);
    run_instr(OP_J, 1'b0);
    run_instr(6'b101010, 1'b0);
    run_instr(OP_ORI, 1'b0);
    run_instr(OP_SLT, 1'b0);

    // Random stream: mix of legal opcodes and arbitrary (non-halt) codes.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 11)];
      else op = 6'($urandom_range(0, 62));
      run_instr(op, 1'($urandom_range(0, 1)));
    end

    run_halt();
    do_reset();

    // Reset mid-lw while in MEM.
    bus.opcode = OP_LW;
    bus.zero = 1'b0;
    #1;
    chk("lw abort k=1 state", 32'(bus.state), 32'd0);
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    #1;
    chk("lw abort MEM state", 32'(bus.state), 32'd3);
    chk("lw abort MEM mRD",   32'(bus.mRD),   32'd1);
    do_reset();
    run_instr(OP_AND, 1'b0);
    run_instr(OP_OR, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multicycle control unit for the CPU; sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the PC's write-enable and next-address select.
- Also drives the IR, register-file, ALU, data-memory and extender controls from a Moore state machine decoded with opcode and the ALU zero flag.
- Sits between the instruction register (opcode source) and the datapath.

Parameters:
- OPW, 6, opcode width.
- CNTW, 32, retired-instruction counter width.

Ports:
- CLK  in  1  system clock; the state register updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- opcode  in  OPW  instruction bits [31:26] from IR; stable from the end of sIF.
- zero  in  1  ALU zero flag, valid during the EXE state.
- PCWre  out  1  PC write enable; the PC captures on the falling CLK edge inside the asserting cycle.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = jump target.
- IRWre  out  1  IR load.
- RegWre  out  1  register-file write.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- ALUSrcB  out  1  ALU B operand: 1 = extended immediate, 0 = rt.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 slt.
- ExtSel  out  1  extender mode: 1 = sign, 0 = zero.
- mRD  out  1  data-memory read.
- mWR  out  1  data-memory write.
- DBDataSrc  out  1  write-back source: 1 = memory, 0 = ALU.
- state  out  3  current state encoding, for debug.
- halted  out  1  high while in sHALT.
- illegal  out  1  sticky; set on an undefined opcode.
- retired  out  CNTW  count of retired instructions.

Behaviour:
- Opcodes, fixed:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110
  - sw 110000, lw 110001, beq 110100, bne 110101, j 111000, halt 111111
  - all others are illegal.
- State encodings: sIF 000, sID 001, sEXE_LS 010, sMEM 011, sWB_LD 100, sEXE_BR 101, sEXE_AL 110, sWB_AL 111. sHALT is state=001 with halted=1, held in a separate flag.
- Transitions:
  - sIF always goes to sID.
  - sID:
    - ALU ops go to sEXE_AL.
    - sw and lw go to sEXE_LS.
    - beq and bne go to sEXE_BR.
    - j and illegal opcodes go to sIF.
    - halt goes to sHALT.
  - sEXE_AL goes to sWB_AL; sWB_AL goes to sIF.
  - sEXE_LS goes to sMEM; sMEM goes to sIF for sw and to sWB_LD for lw; sWB_LD goes to sIF.
  - sEXE_BR goes to sIF.
  - sHALT stays in sHALT until reset.
- Cycle counts: j 2, beq/bne 3, ALU ops 4, sw 4, lw 5.
- Output decode: outputs are combinational from state, opcode and zero; any control not listed below is 0.
  - IRWre = 1 in sIF only.
  - PCWre = 1 exactly once per instruction, in its last cycle: sWB_AL, sWB_LD, sMEM (sw only), sEXE_BR, or sID (j or illegal). It is never 1 in sHALT.
  - PCSrc:
    - 10 in sID for j.
    - 01 in sEXE_BR when (beq and zero=1) or (bne and zero=0).
    - 00 otherwise.
  - ALUOp:
    - add for add, addi, sw, lw.
    - sub for sub, beq, bne.
    - or for or, ori.
    - and for and.
    - slt for slt.
    - Held through EXE and WB.
  - ALUSrcB = 1 for addi, ori, sw, lw.
  - ExtSel = 0 for ori, 1 otherwise.
  - RegDst = 1 for R-type ops (add, sub, or, and, slt).
  - RegWre = 1 in sWB_AL and sWB_LD only.
  - DBDataSrc = 1 in sWB_LD.
  - mRD = 1 in sMEM for lw; mWR = 1 in sMEM for sw.
- retired increments by 1 on each rising edge where PCWre = 1. It wraps modulo 2^CNTW.
- illegal is set on the rising edge leaving sID with an undefined opcode and is cleared only by reset.
- Reset (Reset=0, asynchronous):
  - state = sIF, halted = 0, illegal = 0, retired = 0.
  - The decoded outputs take their sIF values (IRWre = 1, all others 0).
  - Reset asserted mid-instruction aborts the instruction with no PCWre, RegWre or mWR pulse.
  - On reset release, fetch restarts at the next rising edge.
- zero is sampled only in sEXE_BR; changes on zero in any other state have no effect.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams
  - state encodings
  - ALUOp codes
  - PCSrc codes
- Sub-module ctrl_decode: purely combinational, mapping (state, opcode, zero) to control outputs. The top holds the state, halted, illegal and retired registers.

Test Plan:
- Reset held low, then released → state=000, IRWre=1, PCWre=0, retired=0; the first rising edge gives state=001.
- Stream add, addi, lw, sw → cycle counts 4, 4, 5, 4. Each instruction shows one PCWre with PCSrc=00, and retired=4 after 17 cycles. lw shows mRD=1 in 011 and RegWre=DBDataSrc=1 in 100.
- beq with zero=1, then beq with zero=0, then bne with zero=0 → PCSrc = 01, 00, 01 in state 101, each alongside PCWre=1; 3 cycles each.
- j → PCWre=1 and PCSrc=10 in sID, back to sIF after 2 cycles; retired increments by 1.
- Opcode 101010 → illegal=1 from the edge leaving sID, PCWre=1 with PCSrc=00 in sID, then normal fetch; illegal stays 1 through subsequent instructions.
- halt → halted=1 and PCWre stays 0 for 20 cycles. Reset asserted mid-lw in sMEM → immediate state=000, mRD=0, no RegWre pulse, halted=0, retired=0.
